coef_writer: RTL and testbench

- Writer side of the FIR coefficient memory: accepts a stream of coefficient words over a valid/ready handshake.
- Writes each word into a synchronous-write coefficient RAM at consecutive addresses 0..NUM_TAPS-1.
- Signals completion or a framing error.
- Sits between the host/config path and the coefficient store the FIR datapath reads from.

---
 rtl/coef_writer.sv | 108 ++++++++++
 tb/tb_coef_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/coef_writer.sv
// Coefficient RAM writer: streams valid/ready words into consecutive RAM
// addresses, reporting completion and framing errors for each load.
module coef_writer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_TAPS   = 32
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TAPS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_done;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_count;

  logic w_in_load;
  logic w_start;
  logic w_accept;
  logic w_at_last;
  logic w_final;
  logic w_bad;

  // Handshake and termination decode; ready comes from the state register only.
  always_comb begin
    w_in_load   = (r_state == S_LOAD);
    w_start     = (r_state == S_IDLE) & start_i;
    w_accept    = w_in_load & s_valid_i;
    w_at_last   = (r_addr == LAST_IDX);
    w_final     = w_accept & (w_at_last | s_last_i);
    w_bad       = w_accept & (w_at_last ^ s_last_i);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_final) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write port, address walk and load status.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
    end else begin
      r_wr_en <= w_accept;
      r_done  <= w_final;
      if (w_start) begin
        r_addr  <= '0;
        r_err   <= 1'b0;
        r_count <= '0;
      end else if (w_accept) begin
        r_wr_addr <= r_addr;
        r_wr_data <= s_data_i;
        r_count   <= r_count + CNT_WIDTH'(1);
        // The address parks on the last tap so it never wraps.
        if (!w_final) r_addr <= r_addr + ADDR_WIDTH'(1);
        if (w_bad) r_err <= 1'b1;
      end
    end
  end

  assign s_ready_o = w_in_load;
  assign busy_o    = w_in_load;
  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign count_o   = r_count;

endmodule

// File: tb/tb_coef_writer.sv
// Randomized scoreboard bench for coef_writer with a 4-tap, 2-bit-address
// configuration so the last tap sits on the top address.
module tb_coef_writer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 2;
  localparam int unsigned NT = 4;

  logic          clk = 1'b0;
  logic          arstn;
  logic          start;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  coef_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(NT)) dut (
    .clk_i(clk), .arstn_i(arstn), .start_i(start), .s_data_i(s_data),
    .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .err_o(err), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    bit          fin;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] ram [NT];

  // Reference model: whether a load is open, how many words it has taken,
  // and whether it has been framed badly.
  bit          m_load  = 1'b0;
  bit          m_err   = 1'b0;
  int unsigned m_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      m_load  = 1'b0;
      m_err   = 1'b0;
      m_count = 0;
      exp_q.delete();
    end else if (!m_load) begin
      if (start) begin
        m_load  = 1'b1;
        m_err   = 1'b0;
        m_count = 0;
      end
    end else if (s_valid) begin
      exp_t e;
      bit   full;
      full   = (m_count == NT - 1);
      e.addr = m_count;
      e.data = s_data;
      e.fin  = full || s_last;
      exp_q.push_back(e);
      m_count++;
      if (full != s_last) m_err = 1'b1;
      if (e.fin) m_load = 1'b0;
    end
  end

  // Monitor: per-cycle status plus write scoreboard.
  always @(negedge clk) begin
    chk("busy", busy, m_load);
    chk("s_ready", s_ready, m_load);
    chk("err", err, m_err);
    chk("count", count, m_count);
    if (wr_en) begin
      ram[wr_addr] = wr_data;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected at %0t",
                 wr_addr, wr_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("done", done, e.fin);
      end
    end else begin
      chk("done_no_write", done, 0);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_write: no wr_en, expected addr %0h data %0h at %0t",
                 e.addr, e.data, $time);
      end
    end
  end

  task automatic drive(input bit st, input bit v, input bit l, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    start   = st;
    s_valid = v;
    s_last  = l;
    s_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, DW'($urandom));
  endtask

  task automatic check_ram(input logic [DW-1:0] w [NT], input int n);
    for (int i = 0; i < n; i++) chk($sformatf("ram%0d", i), ram[i], w[i]);
  endtask

  initial begin
    logic [DW-1:0] w [NT];
    arstn   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 arstn = 1'b1;
    idle(2);

    // Nominal load.
    w[0] = 16'h0011; w[1] = 16'h0022; w[2] = 16'h0033; w[3] = 16'h0044;
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < NT; i++) drive(1'b0, 1'b1, i == NT - 1, w[i]);
    idle(3);
    check_ram(w, NT);
    chk("nominal_count", count, 4);
    chk("nominal_err", err, 0);

    // Throttled source.
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < NT; i++) begin
      w[i] = DW'($urandom);
      idle($urandom_range(0, 2));
      drive(1'b0, 1'b1, i == NT - 1, w[i]);
    end
    idle(3);
    check_ram(w, NT);

    // Too short: last on word 2, then a stray word while idle.
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 16'hA000);
    drive(1'b0, 1'b1, 1'b1, 16'hA001);
    drive(1'b0, 1'b1, 1'b0, 16'hA002);
    idle(2);
    chk("short_err", err, 1);
    chk("short_count", count, 2);

    // Too long: no last on word 4, a fifth word must be refused.
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < NT; i++) drive(1'b0, 1'b1, 1'b0, DW'(16'hB000 + i));
    drive(1'b0, 1'b1, 1'b1, 16'hB004);
    idle(2);
    chk("long_err", err, 1);
    chk("long_count", count, 4);
    drive(1'b1, 1'b0, 1'b0, '0);
    idle(1);
    chk("long_err_cleared", err, 0);
    chk("restart_busy", busy, 1);
    // Start while loading and back-to-back restart in the done cycle.
    drive(1'b0, 1'b1, 1'b0, 16'hC000);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 16'hC001);
    drive(1'b0, 1'b1, 1'b0, 16'hC002);
    drive(1'b0, 1'b1, 1'b1, 16'hC003);
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < NT; i++) drive(1'b0, 1'b1, i == NT - 1, DW'(16'hD000 + i));
    idle(2);
    chk("b2b_count", count, 4);

    // Reset coincident with the third handshake, then a clean load.
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 16'hE000);
    drive(1'b0, 1'b1, 1'b0, 16'hE001);
    drive(1'b0, 1'b1, 1'b0, 16'hE002);
    arstn = 1'b0;
    @(negedge clk);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_count", count, 0);
    idle(2);
    arstn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < NT; i++) begin
      w[i] = DW'($urandom);
      drive(1'b0, 1'b1, i == NT - 1, w[i]);
    end
    idle(2);
    check_ram(w, NT);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 4) == 0, DW'($urandom));
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
